// File: rtl/hi_lo_muldiv_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface hi_lo_muldiv_unit_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, funct, operand_a, operand_b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, funct, operand_a, operand_b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/hi_lo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers, plus MTHI/MTLO writes.
// Optional MULDIV_SINGLE_CYCLE_MULT_EN: multiplies complete combinationally in one cycle.
module hi_lo_muldiv_unit (
    input  logic                  clk,
    input  logic                  reset_n,
    hi_lo_muldiv_unit_if.slave    bus
);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        if (sgn) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end else begin
            ea = {32'd0, a};
            eb = {32'd0, b};
        end
        return ea * eb;
    endfunction
`endif

    state_t      state_r;
    state_t      state_nxt;
    logic [4:0]  cnt_r;
    logic [63:0] work_r;
    logic [32:0] rem_r;
    logic [31:0] addend_r;
    logic        op_div_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        div_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        is_mul_s;
    logic        is_div_s;
    logic        is_signed_s;
    logic        is_mthi_s;
    logic        is_mtlo_s;
    logic        accept_s;
    logic        start_iter_s;
    logic        fast_mul_s;
    logic [63:0] fast_prod_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;

    logic [32:0] mul_sum_s;
    logic [63:0] mul_nxt_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_diff_s;
    logic [32:0] rem_nxt_s;
    logic [31:0] quo_nxt_s;
    logic [63:0] prod_fin_s;
    logic [31:0] quo_fin_s;
    logic [31:0] rem_fin_s;

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // Decode the funct field into operation classes.
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        is_mthi_s   = 1'b0;
        is_mtlo_s   = 1'b0;
        case (bus.funct)
            FN_MULT: begin
                is_mul_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            FN_MULTU: is_mul_s = 1'b1;
            FN_DIV: begin
                is_div_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            FN_DIVU:  is_div_s  = 1'b1;
            FN_MTHI:  is_mthi_s = 1'b1;
            FN_MTLO:  is_mtlo_s = 1'b1;
            default: begin
                is_mul_s = 1'b0;
            end
        endcase
    end

    // Requests are only honoured while idle; anything arriving while busy is dropped.
    assign accept_s = bus.start & (state_r == ST_IDLE);
    assign mag_a_s  = mag32(bus.operand_a, is_signed_s);
    assign mag_b_s  = mag32(bus.operand_b, is_signed_s);

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
    assign start_iter_s = accept_s & is_div_s;
    assign fast_mul_s   = accept_s & is_mul_s;
    assign fast_prod_s  = mul64(bus.operand_a, bus.operand_b, is_signed_s);
`else
    assign start_iter_s = accept_s & (is_mul_s | is_div_s);
    assign fast_mul_s   = 1'b0;
    assign fast_prod_s  = 64'd0;
`endif

    // Next-state logic for the IDLE/RUN/FINISH sequencer.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_iter_s) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == 5'd0) begin
                    state_nxt = ST_FINISH;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // One shift-add step (low half of work_r holds the remaining multiplier bits)
    // and one restoring-division step (low half of work_r shifts dividend out, quotient in).
    always_comb begin
        mul_sum_s = {1'b0, work_r[63:32]} + {1'b0, addend_r};
        if (work_r[0]) begin
            mul_nxt_s = {mul_sum_s, work_r[31:1]};
        end else begin
            mul_nxt_s = {1'b0, work_r[63:1]};
        end
        div_shift_s = {rem_r[31:0], work_r[31]};
        div_diff_s  = div_shift_s - {1'b0, addend_r};
        if (div_diff_s[32]) begin
            rem_nxt_s = div_shift_s;
            quo_nxt_s = {work_r[30:0], 1'b0};
        end else begin
            rem_nxt_s = div_diff_s;
            quo_nxt_s = {work_r[30:0], 1'b1};
        end
    end

    // Sign correction; a zero divisor leaves the dividend as remainder and forces all-ones quotient.
    always_comb begin
        if (neg_q_r) begin
            prod_fin_s = neg64(work_r);
        end else begin
            prod_fin_s = work_r;
        end
        if (div_zero_r) begin
            quo_fin_s = 32'hFFFF_FFFF;
        end else if (neg_q_r) begin
            quo_fin_s = neg32(work_r[31:0]);
        end else begin
            quo_fin_s = work_r[31:0];
        end
        if (neg_r_r) begin
            rem_fin_s = neg32(rem_r[31:0]);
        end else begin
            rem_fin_s = rem_r[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Datapath, HI/LO registers and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r      <= 5'd0;
            work_r     <= 64'd0;
            rem_r      <= 33'd0;
            addend_r   <= 32'd0;
            op_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= (state_nxt != ST_IDLE);
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_iter_s) begin
                        cnt_r      <= 5'd31;
                        rem_r      <= 33'd0;
                        op_div_r   <= is_div_s;
                        neg_q_r    <= is_signed_s & (bus.operand_a[31] ^ bus.operand_b[31]);
                        neg_r_r    <= is_signed_s & bus.operand_a[31];
                        div_zero_r <= is_div_s & (bus.operand_b == 32'd0);
                        if (is_div_s) begin
                            work_r   <= {32'd0, mag_a_s};
                            addend_r <= mag_b_s;
                        end else begin
                            work_r   <= {32'd0, mag_b_s};
                            addend_r <= mag_a_s;
                        end
                    end else if (fast_mul_s) begin
                        hi_r   <= fast_prod_s[63:32];
                        lo_r   <= fast_prod_s[31:0];
                        done_r <= 1'b1;
                    end else if (accept_s && is_mthi_s) begin
                        hi_r <= bus.operand_a;
                    end else if (accept_s && is_mtlo_s) begin
                        lo_r <= bus.operand_a;
                    end
                end
                ST_RUN: begin
                    if (cnt_r != 5'd0) begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                    if (op_div_r) begin
                        rem_r        <= rem_nxt_s;
                        work_r[31:0] <= quo_nxt_s;
                    end else begin
                        work_r <= mul_nxt_s;
                    end
                end
                ST_FINISH: begin
                    done_r <= 1'b1;
                    if (op_div_r) begin
                        hi_r <= rem_fin_s;
                        lo_r <= quo_fin_s;
                    end else begin
                        hi_r <= prod_fin_s[63:32];
                        lo_r <= prod_fin_s[31:0];
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Directed and randomized checks of hi_lo_muldiv_unit against an arithmetic reference model.
module tb_hi_lo_muldiv_unit;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   passed;
    int   failed;
    int   total;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hi_lo_muldiv_unit_if bus_if ();

    hi_lo_muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain 64-bit integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (f)
            FN_MULT:  res = sa * sb;
            FN_MULTU: res = ua * ub;
            FN_DIV: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            FN_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a mult/div in the current cycle and check every cycle through the result.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int inj_cyc);
        int lat;
        lat = ((f == FN_MULT || f == FN_MULTU) && FAST_MUL) ? 1 : 34;
        check({tag, " c0 busy"}, {31'd0, bus_if.busy}, 32'd0);
        bus_if.start     = 1'b1;
        bus_if.funct     = f;
        bus_if.operand_a = a;
        bus_if.operand_b = b;
        @(posedge clk); #1;
        for (int c = 1; c < lat; c++) begin
            if (c == inj_cyc) begin
                bus_if.start     = 1'b1;
                bus_if.funct     = FN_MTLO;
                bus_if.operand_a = 32'hDEAD_BEEF;
            end else begin
                bus_if.start = 1'b0;
            end
            check($sformatf("%s c%0d busy", tag, c), {31'd0, bus_if.busy}, 32'd1);
            check($sformatf("%s c%0d done", tag, c), {31'd0, bus_if.done}, 32'd0);
            check($sformatf("%s c%0d hi", tag, c), bus_if.hi, m_hi);
            check($sformatf("%s c%0d lo", tag, c), bus_if.lo, m_lo);
            @(posedge clk); #1;
        end
        bus_if.start = 1'b0;
        check({tag, " result done"}, {31'd0, bus_if.done}, 32'd1);
        check({tag, " result busy"}, {31'd0, bus_if.busy}, 32'd0);
        check({tag, " result hi"}, bus_if.hi, ehi);
        check({tag, " result lo"}, bus_if.lo, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    task automatic run_model(input string tag, input logic [5:0] f, input logic [31:0] a,
                             input logic [31:0] b);
        logic [63:0] e;
        e = ref_result(f, a, b);
        run_op(tag, f, a, b, e[63:32], e[31:0], 0);
    endtask

    task automatic move_to(input string tag, input logic [5:0] f, input logic [31:0] a);
        check({tag, " c0 busy"}, {31'd0, bus_if.busy}, 32'd0);
        bus_if.start     = 1'b1;
        bus_if.funct     = f;
        bus_if.operand_a = a;
        bus_if.operand_b = 32'd0;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        if (f == FN_MTHI) m_hi = a;
        else              m_lo = a;
        check({tag, " hi"}, bus_if.hi, m_hi);
        check({tag, " lo"}, bus_if.lo, m_lo);
        check({tag, " busy"}, {31'd0, bus_if.busy}, 32'd0);
        check({tag, " done"}, {31'd0, bus_if.done}, 32'd0);
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        passed = 0;
        failed = 0;
        total  = 0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        reset_n          = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.funct     = 6'd0;
        bus_if.operand_a = 32'd0;
        bus_if.operand_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", bus_if.hi, 32'd0);
        check("reset lo", bus_if.lo, 32'd0);
        check("reset busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset done", {31'd0, bus_if.done}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult_neg", FN_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("div_neg", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("divu_zero", FN_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
        run_op("div_zero_neg", FN_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        @(posedge clk); #1;
        check("idle done", {31'd0, bus_if.done}, 32'd0);

        move_to("mthi", FN_MTHI, 32'h1234_5678);
        run_op("multu_inj", FN_MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 10);

        // Reset in the middle of a divide discards it.
        move_to("mthi2", FN_MTHI, 32'hA5A5_A5A5);
        move_to("mtlo2", FN_MTLO, 32'h5A5A_5A5A);
        bus_if.start     = 1'b1;
        bus_if.funct     = FN_DIVU;
        bus_if.operand_a = 32'd1000;
        bus_if.operand_b = 32'd3;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst mid hi", bus_if.hi, 32'd0);
        check("rst mid lo", bus_if.lo, 32'd0);
        check("rst mid busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst mid done", {31'd0, bus_if.done}, 32'd0);
        reset_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check($sformatf("post rst done %0d", i), {31'd0, bus_if.done}, 32'd0);
            check($sformatf("post rst busy %0d", i), {31'd0, bus_if.busy}, 32'd0);
        end
        run_op("divu_after_rst", FN_DIVU, 32'd1000, 32'd3, 32'h0000_0001, 32'h0000_014D, 0);

        // Randomized operations, back to back, with boundary operands mixed in.
        for (int i = 0; i < 40; i++) begin
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 15);
                default: b = b;
            endcase
            case ($urandom_range(0, 5))
                0: f = FN_MULT;
                1: f = FN_MULTU;
                2: f = FN_DIV;
                3: f = FN_DIVU;
                4: f = FN_MTHI;
                default: f = FN_MTLO;
            endcase
            if (f == FN_MTHI || f == FN_MTLO) begin
                move_to($sformatf("rnd%0d mt", i), f, a);
            end else begin
                run_model($sformatf("rnd%0d f%b a%h b%h", i, f, a, b), f, a, b);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
